// File: rtl/control_sequencer.sv
// control_sequencer: SAP-style fetch/decode/execute controller.
// Produces the per-cycle control word for PC, MAR, RAM, IR, accumulator,
// B register, add/subtract ALU and output register. The ALU result is
// registered, so ALU_WAIT wait states sit between the B load and ALU_OE.
module control_sequencer #(
  parameter int unsigned OPW      = 4,
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] OPCODE,
  output logic           PC_INC,
  output logic           PC_OE,
  output logic           MAR_LD,
  output logic           RAM_OE,
  output logic           IR_LD,
  output logic           IR_OE,
  output logic           ACC_LD,
  output logic           ACC_OE,
  output logic           BREG_LD,
  output logic           SUB,
  output logic           ALU_OE,
  output logic           OUT_LD,
  output logic           HALT,
  output logic           INSTR_DONE
);

  localparam int unsigned WCW = 2;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

  // Last value of the wait counter before leaving E3 (E3 unused when ALU_WAIT is 0).
  localparam logic [WCW-1:0] WAIT_LAST = (ALU_WAIT == 0) ? '0 : WCW'(ALU_WAIT - 1);
  localparam bit             HAS_WAIT  = (ALU_WAIT != 0);

  typedef enum logic [2:0] {
    S_F1,
    S_F2,
    S_F3,
    S_E1,
    S_E2,
    S_E3,
    S_E4,
    S_HALTED
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  // In E1 the IR is freshly loaded and op_q is stale, so decode OPCODE directly.
  logic [OPW-1:0] dec_op_c;
  logic           is_lda_c;
  logic           is_alu_c;
  logic           is_mem_c;
  logic           is_out_c;
  logic           is_hlt_c;
  logic           op_is_sub_c;

  assign dec_op_c    = (state_q == S_E1) ? OPCODE : op_q;
  assign is_lda_c    = (dec_op_c == OP_LDA);
  assign is_alu_c    = (dec_op_c == OP_ADD) || (dec_op_c == OP_SUB);
  assign is_mem_c    = is_lda_c || is_alu_c;
  assign is_out_c    = (dec_op_c == OP_OUT);
  assign is_hlt_c    = (dec_op_c == OP_HLT);
  assign op_is_sub_c = (op_q == OP_SUB);

  // State register with synchronous reset back to fetch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_F1;
      op_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: fetch ring, opcode capture in E1, ALU wait counting in E3.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_F1: state_d = S_F2;
      S_F2: state_d = S_F3;
      S_F3: state_d = S_E1;
      S_E1: begin
        op_d = OPCODE;
        if (is_mem_c) begin
          state_d = S_E2;
        end else if (is_hlt_c) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_F1;
        end
      end
      S_E2: begin
        if (is_alu_c) begin
          state_d = HAS_WAIT ? S_E3 : S_E4;
        end else begin
          state_d = S_F1;
        end
      end
      S_E3: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = S_E4;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_E4:     state_d = S_F1;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_F1;
    endcase
  end

  // Control word decode from registered state, op_q and (in E1 only) OPCODE.
  always_comb begin
    PC_INC     = 1'b0;
    PC_OE      = 1'b0;
    MAR_LD     = 1'b0;
    RAM_OE     = 1'b0;
    IR_LD      = 1'b0;
    IR_OE      = 1'b0;
    ACC_LD     = 1'b0;
    ACC_OE     = 1'b0;
    BREG_LD    = 1'b0;
    SUB        = 1'b0;
    ALU_OE     = 1'b0;
    OUT_LD     = 1'b0;
    HALT       = 1'b0;
    INSTR_DONE = 1'b0;
    unique case (state_q)
      S_F1: begin
        PC_OE  = 1'b1;
        MAR_LD = 1'b1;
      end
      S_F2: PC_INC = 1'b1;
      S_F3: begin
        RAM_OE = 1'b1;
        IR_LD  = 1'b1;
      end
      S_E1: begin
        if (is_mem_c) begin
          IR_OE  = 1'b1;
          MAR_LD = 1'b1;
        end else if (is_out_c) begin
          ACC_OE     = 1'b1;
          OUT_LD     = 1'b1;
          INSTR_DONE = 1'b1;
        end else if (!is_hlt_c) begin
          INSTR_DONE = 1'b1;
        end
      end
      S_E2: begin
        RAM_OE = 1'b1;
        SUB    = op_is_sub_c;
        if (is_lda_c) begin
          ACC_LD     = 1'b1;
          INSTR_DONE = 1'b1;
        end else begin
          BREG_LD = 1'b1;
        end
      end
      // SUB held through the wait so the registered ALU result sees the new B.
      S_E3: SUB = op_is_sub_c;
      S_E4: begin
        SUB        = op_is_sub_c;
        ALU_OE     = 1'b1;
        ACC_LD     = 1'b1;
        INSTR_DONE = 1'b1;
      end
      S_HALTED: HALT = 1'b1;
      default: begin
        PC_OE  = 1'b0;
        MAR_LD = 1'b0;
      end
    endcase
  end

  // At most one bus driver enabled in any cycle.
  always @(posedge CLK) begin
    if (!RST) begin
      assert ($onehot0({PC_OE, RAM_OE, IR_OE, ACC_OE, ALU_OE}));
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction control-word model plus a
// small clocked SAP datapath for end-to-end ALU checks.
module tb_control_sequencer;

  localparam int unsigned OPW      = 4;
  localparam int unsigned ALU_WAIT = 1;
  localparam int          BUDGET   = 60;

  typedef logic [13:0] cw_t;

  localparam cw_t B_PC_INC  = 14'h2000;
  localparam cw_t B_PC_OE   = 14'h1000;
  localparam cw_t B_MAR_LD  = 14'h0800;
  localparam cw_t B_RAM_OE  = 14'h0400;
  localparam cw_t B_IR_LD   = 14'h0200;
  localparam cw_t B_IR_OE   = 14'h0100;
  localparam cw_t B_ACC_LD  = 14'h0080;
  localparam cw_t B_ACC_OE  = 14'h0040;
  localparam cw_t B_BREG_LD = 14'h0020;
  localparam cw_t B_SUB     = 14'h0010;
  localparam cw_t B_ALU_OE  = 14'h0008;
  localparam cw_t B_OUT_LD  = 14'h0004;
  localparam cw_t B_HALT    = 14'h0002;
  localparam cw_t B_DONE    = 14'h0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] opcode;
  logic [3:0] opcode_v;
  bit         use_dp;
  logic pc_inc, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe, acc_ld, acc_oe;
  logic breg_ld, sub, alu_oe, out_ld, halt, instr_done;

  int n_pass  = 0;
  int n_total = 0;

  // Datapath model (environment around the sequencer).
  logic [7:0] ram [16];
  logic [3:0] pc, mar;
  logic [7:0] ir, acc, breg, alu_q, out_reg, bus;

  assign opcode = use_dp ? ir[7:4] : opcode_v;

  cw_t cw;
  assign cw = {pc_inc, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe, acc_ld, acc_oe,
               breg_ld, sub, alu_oe, out_ld, halt, instr_done};

  control_sequencer #(.OPW(OPW), .ALU_WAIT(ALU_WAIT)) dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode),
    .PC_INC(pc_inc), .PC_OE(pc_oe), .MAR_LD(mar_ld), .RAM_OE(ram_oe),
    .IR_LD(ir_ld), .IR_OE(ir_oe), .ACC_LD(acc_ld), .ACC_OE(acc_oe),
    .BREG_LD(breg_ld), .SUB(sub), .ALU_OE(alu_oe), .OUT_LD(out_ld),
    .HALT(halt), .INSTR_DONE(instr_done)
  );

  always_comb begin
    bus = 8'h00;
    if (pc_oe)       bus = {4'h0, pc};
    else if (ram_oe) bus = ram[mar];
    else if (ir_oe)  bus = {4'h0, ir[3:0]};
    else if (acc_oe) bus = acc;
    else if (alu_oe) bus = alu_q;
  end

  always @(posedge clk) begin
    if (rst) begin
      pc <= '0; mar <= '0; ir <= '0; acc <= '0; breg <= '0; alu_q <= '0; out_reg <= '0;
    end else begin
      if (pc_inc)  pc      <= pc + 4'd1;
      if (mar_ld)  mar     <= bus[3:0];
      if (ir_ld)   ir      <= bus;
      if (acc_ld)  acc     <= bus;
      if (breg_ld) breg    <= bus;
      if (out_ld)  out_reg <= bus;
      alu_q <= sub ? (acc - breg) : (acc + breg);
    end
  end

  // Reference: the full cycle-by-cycle control-word list of one instruction.
  task automatic build_exp(input logic [3:0] op, output cw_t q[$]);
    cw_t s;
    q = {};
    q.push_back(B_PC_OE | B_MAR_LD);
    q.push_back(B_PC_INC);
    q.push_back(B_RAM_OE | B_IR_LD);
    case (op)
      4'h0: begin
        q.push_back(B_IR_OE | B_MAR_LD);
        q.push_back(B_RAM_OE | B_ACC_LD | B_DONE);
      end
      4'h1, 4'h2: begin
        s = (op == 4'h2) ? B_SUB : 14'h0;
        q.push_back(B_IR_OE | B_MAR_LD);
        q.push_back(B_RAM_OE | B_BREG_LD | s);
        for (int k = 0; k < int'(ALU_WAIT); k++) q.push_back(s);
        q.push_back(B_ALU_OE | B_ACC_LD | B_DONE | s);
      end
      4'hE: q.push_back(B_ACC_OE | B_OUT_LD | B_DONE);
      4'hF: q.push_back(14'h0);
      default: q.push_back(B_DONE);
    endcase
  endtask

  // Runs n cycles from a negedge, presenting op in E1 (random elsewhere if scramble).
  task automatic capture(input logic [3:0] op, input int n, input bit scramble,
                         output cw_t obs[$]);
    obs = {};
    for (int i = 0; i < n; i++) begin
      opcode_v = (i == 3 || !scramble) ? op : 4'($urandom);
      #1;
      obs.push_back(cw);
      @(negedge clk);
    end
  endtask

  // Resets with the datapath attached and runs the program in ram until HALT.
  task automatic dp_run(output int cyc, output logic [7:0] alu_bus,
                        output bit sub_seen, output int sub_drop);
    bit window;
    use_dp   = 1'b1;
    alu_bus  = 8'hxx;
    sub_seen = 1'b0;
    sub_drop = 0;
    window   = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      #1;
      if (breg_ld) window = 1'b1;
      if (sub) sub_seen = 1'b1;
      if (window && !sub && ir[7:4] == 4'h2) sub_drop++;
      if (alu_oe) begin
        alu_bus = bus;
        window  = 1'b0;
      end
      if (halt) break;
      @(negedge clk);
    end
    @(negedge clk);
    use_dp = 1'b0;
  endtask

  task automatic test_reset();
    cw_t q[$];
    cw_t obs[$];
    rst      = 1'b1;
    use_dp   = 1'b0;
    opcode_v = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (cw !== (B_PC_OE | B_MAR_LD)) $display("FAIL reset_hold got=%h exp=%h", cw, B_PC_OE | B_MAR_LD);
    else n_pass++;
    rst = 1'b0;
    build_exp(4'h0, q);
    capture(4'h0, q.size(), 1'b0, obs);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (obs[i] !== q[i]) $display("FAIL reset_fetch%0d got=%h exp=%h", i, obs[i], q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lda();
    cw_t q[$];
    cw_t obs[$];
    build_exp(4'h0, q);
    capture(4'h0, q.size(), 1'b1, obs);
    foreach (q[i]) begin
      n_total++;
      if (obs[i] !== q[i]) $display("FAIL lda_word%0d got=%h exp=%h", i, obs[i], q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_all_opcodes();
    cw_t q[$];
    cw_t obs[$];
    for (int op = 0; op < 15; op++) begin
      build_exp(4'(op), q);
      capture(4'(op), q.size(), 1'b1, obs);
      foreach (q[i]) begin
        n_total++;
        if (obs[i] !== q[i]) $display("FAIL op%h_word%0d got=%h exp=%h", op, i, obs[i], q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    cw_t q[$];
    cw_t obs[$];
    logic [3:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 14));
      build_exp(op, q);
      capture(op, q.size(), 1'b1, obs);
      foreach (q[i]) begin
        n_total++;
        if (obs[i] !== q[i]) $display("FAIL rand%0d_op%h_word%0d got=%h exp=%h", n, op, i, obs[i], q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    cw_t q[$];
    cw_t obs[$];
    build_exp(4'h2, q);
    capture(4'h2, 5, 1'b1, obs);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (obs[i] !== q[i]) $display("FAIL mid_pre%0d got=%h exp=%h", i, obs[i], q[i]);
      else n_pass++;
    end
    // Now in E3; reset must not alter this cycle's word.
    rst      = 1'b1;
    opcode_v = 4'($urandom);
    #1;
    n_total++;
    if (cw !== q[5]) $display("FAIL mid_e3_word got=%h exp=%h", cw, q[5]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    build_exp(4'h5, q);
    capture(4'h5, q.size(), 1'b0, obs);
    foreach (q[i]) begin
      n_total++;
      if (obs[i] !== q[i]) $display("FAIL mid_nop_word%0d got=%h exp=%h", i, obs[i], q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sub_datapath();
    int cyc, drop;
    logic [7:0] ab;
    bit ss;
    foreach (ram[i]) ram[i] = 8'h00;
    ram[0] = 8'h0E; ram[1] = 8'h2F; ram[2] = 8'hE0; ram[3] = 8'hF0;
    ram[14] = 8'h07; ram[15] = 8'h03;
    dp_run(cyc, ab, ss, drop);
    n_total++;
    if (cyc >= BUDGET) $display("FAIL sub_dp_halt_timeout cycles=%0d limit=%0d", cyc, BUDGET);
    else n_pass++;
    n_total++;
    if (ab !== 8'h04) $display("FAIL sub_dp_alu_bus got=%h exp=04", ab);
    else n_pass++;
    n_total++;
    if (drop != 0) $display("FAIL sub_dp_sub_stable drops=%0d exp=0", drop);
    else n_pass++;
    n_total++;
    if (out_reg !== 8'h04) $display("FAIL sub_dp_out got=%h exp=04", out_reg);
    else n_pass++;
  endtask

  task automatic test_add_datapath();
    int cyc, drop;
    logic [7:0] ab;
    bit ss;
    foreach (ram[i]) ram[i] = 8'h00;
    ram[0] = 8'h0E; ram[1] = 8'h1F; ram[2] = 8'hE0; ram[3] = 8'hF0;
    ram[14] = 8'hFF; ram[15] = 8'h02;
    dp_run(cyc, ab, ss, drop);
    n_total++;
    if (cyc >= BUDGET) $display("FAIL add_dp_halt_timeout cycles=%0d limit=%0d", cyc, BUDGET);
    else n_pass++;
    n_total++;
    if (ab !== 8'h01) $display("FAIL add_dp_alu_bus got=%h exp=01", ab);
    else n_pass++;
    n_total++;
    if (ss !== 1'b0) $display("FAIL add_dp_sub_seen got=%b exp=0", ss);
    else n_pass++;
    n_total++;
    if (acc !== 8'h01) $display("FAIL add_dp_acc got=%h exp=01", acc);
    else n_pass++;
  endtask

  task automatic test_halt();
    cw_t q[$];
    cw_t obs[$];
    cw_t e;
    // Fresh start so the halt instruction begins at F1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    build_exp(4'hF, q);
    capture(4'hF, 24, 1'b1, obs);
    for (int i = 0; i < 24; i++) begin
      e = (i < q.size()) ? q[i] : B_HALT;
      n_total++;
      if (obs[i] !== e) $display("FAIL halt_word%0d got=%h exp=%h", i, obs[i], e);
      else n_pass++;
    end
    rst = 1'b1;
    #1;
    n_total++;
    if (cw !== B_HALT) $display("FAIL halt_rst_same_cycle got=%h exp=%h", cw, B_HALT);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    build_exp(4'h0, q);
    capture(4'h0, q.size(), 1'b1, obs);
    foreach (q[i]) begin
      n_total++;
      if (obs[i] !== q[i]) $display("FAIL halt_recover_word%0d got=%h exp=%h", i, obs[i], q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    use_dp   = 1'b0;
    opcode_v = 4'h0;
    test_reset();
    test_lda();
    test_all_opcodes();
    test_random();
    test_reset_mid();
    test_sub_datapath();
    test_add_datapath();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t limit=500000", $time);
    $fatal(1);
  end

endmodule
